// File: rtl/fib_bcd_conv_if.sv
// Stream interface for fib_bcd_conv: binary terms in, packed BCD out.
// The master side is the producer/consumer environment, the slave side is the converter.
interface fib_bcd_conv_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_value;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_bcd
  );

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_bcd
  );
endinterface

// File: rtl/fib_bcd_conv.sv
// fib_bcd_conv: sequential double-dabble converter (one bit per cycle) turning a
// binary Fibonacci term into packed BCD, with valid/ready on both sides.
// Optional feature: define FIB_BCD_SEQ_CHECK_EN to flag a term smaller than the
// previously accepted one on the sticky seq_err output.
module fib_bcd_conv #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  fib_bcd_conv_if.slave    bus,
  output logic             busy,
  output logic             seq_err
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] bin_sr;
  logic [BW-1:0]    bcd_acc;
  logic [BW-1:0]    bcd_adj;
  logic [BW-1:0]    bcd_next;
  logic [CW-1:0]    cnt;
  logic             accept;

  assign bus.in_ready = (state == IDLE) | ((state == DONE) & bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;
  assign busy         = (state == SHIFT);

  // Add-3 correction on every digit that would overflow past 9 when doubled
  always_comb begin
    bcd_adj = bcd_acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_acc[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
      end
    end
  end

  assign bcd_next = {bcd_adj[BW-2:0], bin_sr[WIDTH-1]};

  // Handshake/conversion state machine; the result register only changes on the final shift
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      bin_sr        <= '0;
      bcd_acc       <= '0;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_bcd   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bin_sr  <= bus.in_value;
            bcd_acc <= '0;
            cnt     <= CW'(WIDTH);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_acc <= bcd_next;
          bin_sr  <= {bin_sr[WIDTH-2:0], 1'b0};
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bus.out_bcd   <= bcd_next;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (bus.in_valid) begin
              bin_sr  <= bus.in_value;
              bcd_acc <= '0;
              cnt     <= CW'(WIDTH);
              state   <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FIB_BCD_SEQ_CHECK_EN
  logic [WIDTH-1:0] last_term;
  logic             first_seen;

  // Remember the last accepted term and latch an error if the sequence ever goes down
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_term  <= '0;
      first_seen <= 1'b0;
      seq_err    <= 1'b0;
    end else if (accept) begin
      if (first_seen && (bus.in_value < last_term)) begin
        seq_err <= 1'b1;
      end
      last_term  <= bus.in_value;
      first_seen <= 1'b1;
    end
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_fib_bcd_conv.sv
// Self-checking bench for fib_bcd_conv: directed and random terms compared against
// a decimal-arithmetic BCD model and a simple ordering model for seq_err.
module tb_fib_bcd_conv;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;
  localparam int LAT    = 16;

  logic clk;
  logic rst_n;
  logic busy;
  logic seq_err;

  int total_checks;
  int passed_checks;
  logic exp_seq;
  logic [19:0] prev_bcd;
  logic [15:0] v;
  int stall;

`ifdef FIB_BCD_SEQ_CHECK_EN
  logic [15:0] last_term;
  logic        seen_term;
`endif

  fib_bcd_conv_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  fib_bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .busy    (busy),
    .seq_err (seq_err)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit so a stuck design still ends the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Reference conversion by repeated division by ten
  function automatic logic [19:0] bcdOf(input int unsigned val);
    logic [19:0] r;
    int unsigned t;
    r = '0;
    t = val;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] value, input logic ready);
    bus.in_valid  = valid;
    bus.in_value  = value;
    bus.out_ready = ready;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    assert (observed === expected) passed_checks++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic modelReset();
    exp_seq = 1'b0;
`ifdef FIB_BCD_SEQ_CHECK_EN
    last_term = '0;
    seen_term = 1'b0;
`endif
  endtask

  task automatic noteAccept(input logic [15:0] val);
`ifdef FIB_BCD_SEQ_CHECK_EN
    if (seen_term && (val < last_term)) exp_seq = 1'b1;
    last_term = val;
    seen_term = 1'b1;
`else
    exp_seq = 1'b0;
`endif
  endtask

  task automatic doReset(input int cycles);
    applyStimulus(1'b0, 16'd0, 1'b0);
    rst_n = 1'b0;
    repeat (cycles) tick();
    rst_n = 1'b1;
    #1;
    modelReset();
  endtask

  // Offer a term with out_ready high (IDLE or DONE) and confirm it was taken
  task automatic acceptTerm(input logic [15:0] val);
    applyStimulus(1'b1, val, 1'b1);
    checkOutput("accept_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    noteAccept(val);
    applyStimulus(1'b0, 16'd0, 1'b0);
    checkOutput("accept_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("accept_busy", 32'(busy), 32'd1);
    checkOutput("accept_seq_err", 32'(seq_err), 32'(exp_seq));
  endtask

  // Wait (bounded) for the result and compare latency and digits
  task automatic waitDone(input logic [15:0] val);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(LAT));
    checkOutput("done_out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("done_bcd", 32'(bus.out_bcd), 32'(bcdOf(32'(val))));
    checkOutput("done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_value  = '0;
    bus.out_ready = 1'b0;
    modelReset();

    // Reset state
    doReset(2);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_bcd", 32'(bus.out_bcd), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_seq_err", 32'(seq_err), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Zero, full-scale and a Fibonacci term
    acceptTerm(16'd0);
    waitDone(16'd0);
    applyStimulus(1'b0, 16'd0, 1'b1);
    tick();
    checkOutput("consume_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("consume_keeps_bcd", 32'(bus.out_bcd), 32'h00000);
    checkOutput("consume_in_ready", 32'(bus.in_ready), 32'd1);
    acceptTerm(16'd65535);
    waitDone(16'd65535);
    checkOutput("full_scale_const", 32'(bus.out_bcd), 32'h65535);
    acceptTerm(16'd6765);
    waitDone(16'd6765);

    // Downstream stall for 10 cycles with the next term waiting
    applyStimulus(1'b1, 16'd10946, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall_out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("stall_bcd", 32'(bus.out_bcd), 32'h06765);
      checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    acceptTerm(16'd10946);

    // Term offered during SHIFT is held off, then handed over on the DONE edge
    applyStimulus(1'b1, 16'd89, 1'b0);
    checkOutput("shift_in_ready", 32'(bus.in_ready), 32'd0);
    waitDone(16'd10946);
    acceptTerm(16'd89);
    waitDone(16'd89);
    checkOutput("b2b_const", 32'(bus.out_bcd), 32'h00089);

    // Random terms with random downstream stalls and back-to-back handoffs
    prev_bcd = bcdOf(32'd89);
    for (int k = 0; k < 12; k++) begin
      v = 16'($urandom_range(0, 65535));
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        applyStimulus(1'b1, v, 1'b0);
        checkOutput("rand_stall_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        checkOutput("rand_stall_hold", 32'(bus.out_bcd), 32'(prev_bcd));
      end
      acceptTerm(v);
      waitDone(v);
      prev_bcd = bcdOf(32'(v));
    end

    // Reset in the middle of a conversion discards it
    applyStimulus(1'b0, 16'd0, 1'b1);
    tick();
    acceptTerm(16'd30000);
    repeat (7) tick();
    checkOutput("mid_busy", 32'(busy), 32'd1);
    doReset(1);
    checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_out_bcd", 32'(bus.out_bcd), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_seq_err", 32'(seq_err), 32'd0);
    acceptTerm(16'd21);
    waitDone(16'd21);
    checkOutput("after_rst_const", 32'(bus.out_bcd), 32'h00021);

    // Ordering check sequence after a fresh reset
    doReset(1);
    acceptTerm(16'd1);
    waitDone(16'd1);
    acceptTerm(16'd2);
    waitDone(16'd2);
    acceptTerm(16'd3);
    waitDone(16'd3);
    acceptTerm(16'd5);
    waitDone(16'd5);
    acceptTerm(16'd13);
    waitDone(16'd13);
    acceptTerm(16'd8);
    waitDone(16'd8);
    checkOutput("seq_out_of_order_bcd", 32'(bus.out_bcd), 32'h00008);
    applyStimulus(1'b0, 16'd0, 1'b1);
    repeat (3) tick();
    checkOutput("seq_err_sticky", 32'(seq_err), 32'(exp_seq));

    $display("[TB] %0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
